i2c_slave_regfile: RTL

I2C_SLAVE_REGFILE -- requirements
Module: i2c_slave_regfile

---
 rtl/i2c_slave_regfile.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/i2c_slave_regfile.sv
// I2C slave with a 16x8 register file: write = addr, mem index, data...; read streams from ptr.
// Optional macro I2C_SLAVE_REGFILE_AUTOINC_EN advances ptr after every data byte.
module i2c_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter logic [7:0] RESET_VAL  = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    output logic       wr_valid,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

`ifdef I2C_SLAVE_REGFILE_AUTOINC_EN
    localparam logic [3:0] PTR_STEP = 4'd1;
`else
    localparam logic [3:0] PTR_STEP = 4'd0;
`endif

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, MEM_ADDR, MEM_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
    } state_t;

    state_t      state, state_next;
    logic        scl_s1, scl_s2, scl_d, sda_s1, sda_s2, sda_d;
    logic        scl_rise, scl_fall, start_det, stop_det;
    logic [3:0]  cnt, ptr;
    logic [7:0]  shift, tx;
    logic        rw, mack, oe, oe_next, busy_next;
    logic [7:0]  regs [16];

    assign sda = oe ? 1'b0 : 1'bz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {scl_s1, scl_s2, scl_d} <= 3'b111;
            {sda_s1, sda_s2, sda_d} <= 3'b111;
        end else begin
            {scl_s1, scl_s2, scl_d} <= {scl, scl_s1, scl_s2};
            {sda_s1, sda_s2, sda_d} <= {sda, sda_s1, sda_s2};
        end
    end

    // START/STOP need scl stable high across both samples of the sda transition.
    assign scl_rise  = scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 & scl_d;
    assign start_det = scl_s2 & scl_d & ~sda_s2 & sda_d;
    assign stop_det  = scl_s2 & scl_d & sda_s2 & ~sda_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (start_det) begin
            state_next = ADDR;
        end else if (stop_det) begin
            state_next = IDLE;
        end else if (scl_fall) begin
            case (state)
                ADDR:      if (cnt == 4'd8) state_next = (shift[7:1] == SLAVE_ADDR) ? ADDR_ACK : IDLE;
                ADDR_ACK:  state_next = rw ? RDATA : MEM_ADDR;
                MEM_ADDR:  if (cnt == 4'd8) state_next = MEM_ACK;
                MEM_ACK:   state_next = WDATA;
                WDATA:     if (cnt == 4'd8) state_next = WDATA_ACK;
                WDATA_ACK: state_next = WDATA;
                RDATA:     if (cnt == 4'd8) state_next = RDATA_ACK;
                RDATA_ACK: state_next = mack ? IDLE : RDATA;
                default:   state_next = IDLE;
            endcase
        end
    end

    // sda drive only moves on scl falling edges (or bus conditions that release it).
    always_comb begin
        oe_next   = oe;
        busy_next = busy;
        if (start_det) begin
            oe_next = 1'b0;
        end else if (stop_det) begin
            oe_next   = 1'b0;
            busy_next = 1'b0;
        end else if (scl_fall) begin
            case (state_next)
                ADDR_ACK, MEM_ACK, WDATA_ACK: oe_next = 1'b1;
                RDATA:   oe_next = (state == RDATA) ? ~tx[6] : ~regs[ptr][7];
                default: oe_next = 1'b0;
            endcase
            if (state == ADDR && state_next == ADDR_ACK) busy_next = 1'b1;
            if (state_next == IDLE) busy_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= 4'd0;
            ptr      <= 4'd0;
            shift    <= 8'd0;
            tx       <= 8'd0;
            rw       <= 1'b0;
            mack     <= 1'b1;
            oe       <= 1'b0;
            busy     <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr  <= 4'd0;
            wr_data  <= 8'd0;
            for (int i = 0; i < 16; i++) regs[i] <= RESET_VAL;
        end else begin
            wr_valid <= 1'b0;
            oe       <= oe_next;
            busy     <= busy_next;
            if (start_det || stop_det) begin
                cnt <= 4'd0;
            end else if (scl_rise) begin
                case (state)
                    ADDR, MEM_ADDR, WDATA: begin
                        shift <= {shift[6:0], sda_s2};
                        cnt   <= cnt + 4'd1;
                    end
                    RDATA:     cnt  <= cnt + 4'd1;
                    RDATA_ACK: mack <= sda_s2;
                    default: ;
                endcase
            end else if (scl_fall) begin
                if (cnt == 4'd8) cnt <= 4'd0;
                case (state)
                    ADDR:     if (cnt == 4'd8) rw <= shift[0];
                    MEM_ADDR: if (cnt == 4'd8) ptr <= shift[3:0];
                    WDATA: if (cnt == 4'd8) begin
                        regs[ptr] <= shift;
                        wr_valid  <= 1'b1;
                        wr_addr   <= ptr;
                        wr_data   <= shift;
                    end
                    WDATA_ACK: ptr <= ptr + PTR_STEP;
                    RDATA:     if (cnt == 4'd8) ptr <= ptr + PTR_STEP;
                    default: ;
                endcase
                if (state_next == RDATA) tx <= (state == RDATA) ? {tx[6:0], 1'b0} : regs[ptr];
            end
        end
    end

endmodule
